// File: rtl/ones_pattern_gen_pkg.sv
// ones_pattern_gen_pkg
// Shared constants for the ones-pattern generator: default geometry,
// FSM state encoding and the count clamp value.
package ones_pattern_gen_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int CW_DEF    = $clog2(WIDTH_DEF) + 1;
    localparam int PW_DEF    = $clog2(WIDTH_DEF);

    // Requests asking for more ones than the word holds are clamped to this.
    localparam int CLAMP_CNT = WIDTH_DEF;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUILD = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/ones_pattern_gen_if.sv
// ones_pattern_gen_if
// Request/response bundle for the ones-pattern generator.
//   in_valid/in_ready  : request handshake carrying d_cnt (ones count) and
//                        d_pos (bit index of the first 1)
//   out_valid/out_ready: result handshake carrying d_out (word) and err
//                        (count was clamped)
// master = request source / result consumer, slave = the generator.
interface ones_pattern_gen_if
    import ones_pattern_gen_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CW    = CW_DEF,
    parameter int PW    = PW_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic [CW-1:0]    d_cnt;
    logic [PW-1:0]    d_pos;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d_out;
    logic             err;

    modport master (
        output in_valid, d_cnt, d_pos, out_ready,
        input  in_ready, out_valid, d_out, err
    );

    modport slave (
        input  in_valid, d_cnt, d_pos, out_ready,
        output in_ready, out_valid, d_out, err
    );
endinterface

// File: rtl/ones_pattern_gen.sv
// ones_pattern_gen
// Builds a WIDTH-bit word holding a contiguous, wrapping run of 1s.
// The run starts at d_pos and is min(d_cnt, WIDTH) bits long; one bit is
// set per clock, so the result appears N edges after the accept edge
// (N = clamped count, N = 0 completes on the accept edge itself).
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : ones_pattern_gen_if.slave (request in, result out)
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for a request; in_ready high
// BUILD | setting one bit per edge until remaining reaches zero
// DONE  | result valid; held until out_ready
module ones_pattern_gen
    import ones_pattern_gen_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CW    = CW_DEF,
    parameter int PW    = PW_DEF
) (
    input logic               clk,
    input logic               reset,
    ones_pattern_gen_if.slave bus
);

    localparam logic [CW-1:0] MAX_CNT = CW'(WIDTH);

    logic [1:0]       state;
    logic [CW-1:0]    remaining;
    logic [PW-1:0]    ptr;
    logic [WIDTH-1:0] d_out_q;
    logic             err_q;
    logic [CW-1:0]    cnt_clamped;

    assign cnt_clamped = (bus.d_cnt > MAX_CNT) ? MAX_CNT : bus.d_cnt;

    // Gated with reset so a source never sees ready during reset.
    assign bus.in_ready  = (state == ST_IDLE) && !reset;
    assign bus.out_valid = (state == ST_DONE);
    assign bus.d_out     = d_out_q;
    assign bus.err       = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            remaining <= '0;
            ptr       <= '0;
            d_out_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        remaining <= cnt_clamped;
                        ptr       <= bus.d_pos;
                        d_out_q   <= '0;
                        err_q     <= (bus.d_cnt > MAX_CNT);
                        state     <= (cnt_clamped != '0) ? ST_BUILD : ST_DONE;
                    end
                end
                ST_BUILD: begin
                    d_out_q[ptr] <= 1'b1;
                    // PW-bit pointer wraps from WIDTH-1 to 0 on its own.
                    ptr          <= ptr + PW'(1);
                    remaining    <= remaining - CW'(1);
                    if (remaining == CW'(1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ones_pattern_gen.sv
module tb_ones_pattern_gen;
    import ones_pattern_gen_pkg::*;

    logic clk;
    logic reset;

    ones_pattern_gen_if bus ();

    ones_pattern_gen dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  cnt;
        logic [3:0]  pos;
        logic [15:0] exp_out;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[10];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Waits (bounded) for in_ready, presents one request, and measures the
    // number of edges from the accept edge until out_valid is seen.
    task automatic run_req(input logic [4:0] cnt, input logic [3:0] pos, output int lat);
        int waited;
        waited = 0;
        while (!bus.in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!bus.in_ready) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.d_cnt    = cnt;
        bus.d_pos    = pos;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.d_cnt    = 5'h1f;
        bus.d_pos    = 4'h0;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    function automatic int clamp(input logic [4:0] c);
        return (int'(c) > 16) ? 16 : int'(c);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;

        vecs[0] = '{5'd6,  4'd1,  16'h007E, 1'b0, 6};
        vecs[1] = '{5'd0,  4'd5,  16'h0000, 1'b0, 0};
        vecs[2] = '{5'd5,  4'd14, 16'hC007, 1'b0, 5};
        vecs[3] = '{5'd16, 4'd3,  16'hFFFF, 1'b0, 16};
        vecs[4] = '{5'd20, 4'd3,  16'hFFFF, 1'b1, 16};
        vecs[5] = '{5'd6,  4'd0,  16'h003F, 1'b0, 6};
        vecs[6] = '{5'd31, 4'd7,  16'hFFFF, 1'b1, 16};
        vecs[7] = '{5'd1,  4'd15, 16'h8000, 1'b0, 1};
        vecs[8] = '{5'd8,  4'd12, 16'hF00F, 1'b0, 8};
        vecs[9] = '{5'd15, 4'd0,  16'h7FFF, 1'b0, 15};

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.d_cnt     = '0;
        bus.d_pos     = '0;
        bus.out_ready = 1'b1;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_d_out",     32'(bus.d_out),     32'd0);
        check("rst_err",       32'(bus.err),       32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < 10; i++) begin
            run_req(vecs[i].cnt, vecs[i].pos, lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_d_out", i),   32'(bus.d_out), 32'(vecs[i].exp_out));
            check($sformatf("v%0d_err", i),     32'(bus.err), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_popcount", i), 32'($countones(bus.d_out)),
                  32'(clamp(vecs[i].cnt)));
        end

        // Backpressure: result must hold and new requests must be ignored.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        run_req(5'd3, 4'd0, lat);
        check("bp_latency", 32'(lat), 32'd3);
        bus.in_valid = 1'b1;
        bus.d_cnt    = 5'd9;
        bus.d_pos    = 4'd8;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check($sformatf("bp_hold_c%0d", c),
                  {14'd0, bus.out_valid, bus.in_ready, bus.d_out},
                  {14'd0, 1'b1, 1'b0, 16'h0007});
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
        check("bp_release_in_ready",  32'(bus.in_ready),  32'd1);
        check("bp_d_out_held",        32'(bus.d_out),     32'h0007);

        // Reset in the middle of BUILD discards the partial word.
        bus.in_valid = 1'b1;
        bus.d_cnt    = 5'd10;
        bus.d_pos    = 4'd0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_build_d_out", 32'(bus.d_out), 32'h000F);
        check("mid_build_out_valid", 32'(bus.out_valid), 32'd0);
        reset = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_d_out",     32'(bus.d_out),     32'd0);
        check("mid_rst_in_ready",  32'(bus.in_ready),  32'd0);
        @(posedge clk); #1;
        check("mid_rst_hold_in_ready", 32'(bus.in_ready), 32'd0);
        reset = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.out_valid) check("no_output_after_rst", 32'(bus.out_valid), 32'd0);
        end
        run_req(5'd2, 4'd15, lat);
        check("post_rst_latency", 32'(lat), 32'd2);
        check("post_rst_d_out",   32'(bus.d_out), 32'h8001);
        check("post_rst_err",     32'(bus.err), 32'd0);

        // Reset while DONE is held under backpressure.
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        check("done_hold_out_valid", 32'(bus.out_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("done_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("done_rst_d_out",     32'(bus.d_out),     32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("done_rst_in_ready", 32'(bus.in_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
